// File: rtl/rv32i_types.sv
// Shared RV32I encodings and the load/store controller state type.
// Used by lsu_ctrl (optional feature macro: LSU_MISALIGN_TRAP_EN).
package rv32i_types;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [2:0] {
      lb  = 3'b000,
      lh  = 3'b001,
      lw  = 3'b010,
      lbu = 3'b100,
      lhu = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      sb = 3'b000,
      sh = 3'b001,
      sw = 3'b010
   } store_funct3_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/lsu_ctrl_load_format.sv
// Load data formatting: picks the addressed byte/halfword out of the raw
// memory word and sign- or zero-extends it according to funct3.
module lsu_load_format
   import rv32i_types::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] mem_rdata,
   output logic [31:0] rdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = mem_rdata[7:0];
      case (addr_lo)
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         2'd3:    byte_sel = mem_rdata[31:24];
         default: byte_sel = mem_rdata[7:0];
      endcase

      // Halfword lane comes from addr[1] alone; odd halfword addresses
      // never reach here when misalignment trapping is enabled.
      half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      rdata = '0;
      case (funct3)
         lb:      rdata = {{24{byte_sel[7]}}, byte_sel};
         lbu:     rdata = {24'b0, byte_sel};
         lh:      rdata = {{16{half_sel[15]}}, half_sel};
         lhu:     rdata = {16'b0, half_sel};
         lw:      rdata = mem_rdata;
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the MEM stage and the data-memory port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module lsu_ctrl
   import rv32i_types::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [6:0]        req_opcode,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_trap,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_byte_enable,
   input  logic              mem_resp,
   input  logic [DATA_W-1:0] mem_rdata
);

   lsu_state_t  state, state_next;

   logic        accept;
   logic        is_load;
   logic        is_store;
   logic        misaligned;
   logic [3:0]  req_mask;
   logic [31:0] req_wdata_shifted;

   logic [2:0]  funct3_q;
   logic [1:0]  addr_lo_q;
   logic        is_load_q;
   logic [31:0] load_data;

   assign accept     = req_valid && req_ready;
   assign is_load    = (req_opcode == op_load);
   assign is_store   = (req_opcode == op_store);
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);

   always_comb begin
      req_mask          = 4'b0000;
      req_wdata_shifted = req_wdata;
      if (is_load) begin
         case (req_funct3)
            lb, lbu: req_mask = 4'b0001 << req_addr[1:0];
            lh, lhu: req_mask = req_addr[1] ? 4'b1100 : 4'b0011;
            lw:      req_mask = 4'b1111;
            default: req_mask = 4'b0000;
         endcase
      end else if (is_store) begin
         case (req_funct3)
            sb: begin
               req_mask          = 4'b0001 << req_addr[1:0];
               req_wdata_shifted = {24'b0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
            end
            sh: begin
               req_mask          = req_addr[1] ? 4'b1100 : 4'b0011;
               req_wdata_shifted = req_addr[1] ? {req_wdata[15:0], 16'b0}
                                               : {16'b0, req_wdata[15:0]};
            end
            sw:      req_mask = 4'b1111;
            default: req_mask = 4'b0000;
         endcase
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      misaligned = 1'b0;
      if (is_load) begin
         case (req_funct3)
            lh, lhu: misaligned = req_addr[0];
            lw:      misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
         endcase
      end else if (is_store) begin
         case (req_funct3)
            sh:      misaligned = req_addr[0];
            sw:      misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_trap <= 1'b0;
      end else if (state == IDLE && accept) begin
         resp_trap <= misaligned;
      end
   end
`else
   assign misaligned = 1'b0;
   assign resp_trap  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = ((is_load || is_store) && !misaligned) ? BUSY : RESP;
            end
         end
         BUSY:    if (mem_resp) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Memory-side outputs are registered so they stay stable for the
   // whole BUSY phase regardless of what the pipeline does meanwhile.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_address     <= '0;
         mem_wdata       <= '0;
         mem_byte_enable <= 4'b0000;
         resp_rdata      <= '0;
         funct3_q        <= 3'b000;
         addr_lo_q       <= 2'b00;
         is_load_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  resp_rdata <= '0;
                  if ((is_load || is_store) && !misaligned) begin
                     mem_read        <= is_load;
                     mem_write       <= is_store;
                     mem_address     <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_wdata       <= req_wdata_shifted;
                     mem_byte_enable <= req_mask;
                     funct3_q        <= req_funct3;
                     addr_lo_q       <= req_addr[1:0];
                     is_load_q       <= is_load;
                  end
               end
            end
            BUSY: begin
               if (mem_resp) begin
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  resp_rdata <= is_load_q ? load_data : '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   lsu_load_format u_load_format (
      .funct3    (funct3_q),
      .addr_lo   (addr_lo_q),
      .mem_rdata (mem_rdata),
      .rdata     (load_data)
   );

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: byte-lane reference model, literal
// pinning vectors, reset-in-flight case and randomized transactions.
module tb_lsu_ctrl;
   import rv32i_types::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [6:0]  req_opcode;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_trap;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_enable;
   logic        mem_resp;
   logic [31:0] mem_rdata;

   int checks = 0;
   int passes = 0;

   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [31:0] cap_rdata;
   logic [3:0]  cap_be;
   logic        cap_trap;
   int          cap_strobes;

   lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_opcode      (req_opcode),
      .req_funct3      (req_funct3),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_trap       (resp_trap),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_resp        (mem_resp),
      .mem_rdata       (mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
   endtask

   // Natural access size in bytes; 0 for no-ops and unknown funct3.
   function automatic int accessSize(input logic [6:0] op, input logic [2:0] f3);
      if (op == 7'b0000011) begin
         case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
         endcase
      end else if (op == 7'b0100011) begin
         case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            default: return 0;
         endcase
      end
      return 0;
   endfunction

   function automatic logic [3:0] modelMask(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr);
      int n;
      int off;
      n = accessSize(op, f3);
      if (n == 0) return 4'b0000;
      off = int'(addr % 4) - (int'(addr % 4) % n);
      return 4'(((1 << n) - 1) << off);
   endfunction

   function automatic int lowestLane(input logic [3:0] mask);
      for (int i = 0; i < 4; i++) if (mask[i]) return i;
      return 0;
   endfunction

   function automatic logic [31:0] modelStore(input logic [31:0] wd, input logic [3:0] mask);
      logic [31:0] r;
      int base;
      r = 32'h0;
      base = lowestLane(mask);
      for (int i = 0; i < 4; i++)
         if (mask[i]) r[8*i +: 8] = wd[8*(i-base) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [3:0] mask, input logic [31:0] rd);
      logic [31:0] v;
      logic [31:0] keep;
      int n;
      if (mask == 4'b0000) return 32'h0;
      n = $countones(mask);
      v = rd >> (8 * lowestLane(mask));
      if (n == 4) return v;
      keep = (32'h1 << (8 * n)) - 32'h1;
      v = v & keep;
      if (!f3[2] && v[8*n-1]) v = v | ~keep;
      return v;
   endfunction

   function automatic logic modelTrap(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
      int n;
      n = accessSize(op, f3);
      return (n > 1) && ((int'(addr % 4) % n) != 0);
`else
      return 1'b0;
`endif
   endfunction

   // Runs one transaction starting at a negedge with the DUT idle, and
   // returns with the DUT idle again at a later negedge.
   task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd, input int lat, input bit hold);
      bit          is_ld;
      bit          is_st;
      bit          trap;
      logic [3:0]  mask;
      logic [31:0] exp_rdata;
      is_ld = (op == 7'b0000011);
      is_st = (op == 7'b0100011);
      trap  = modelTrap(op, f3, addr);
      mask  = modelMask(op, f3, addr);
      exp_rdata = is_ld ? modelLoad(f3, mask, rd) : 32'h0;
      cap_addr = 0; cap_wdata = 0; cap_rdata = 0; cap_be = 0; cap_trap = 0; cap_strobes = 0;

      checkOutput("idle_ready", 32'(req_ready), 32'h1);
      checkOutput("idle_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("idle_strobe", 32'({mem_read, mem_write}), 32'h0);
      req_valid  = 1'b1;
      req_opcode = op;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      mem_resp   = 1'($urandom);
      mem_rdata  = $urandom;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      mem_resp  = 1'b0;

      if ((is_ld || is_st) && !trap) begin
         for (int k = 0; k <= lat; k++) begin
            checkOutput("busy_mem_read", 32'(mem_read), 32'(is_ld));
            checkOutput("busy_mem_write", 32'(mem_write), 32'(is_st));
            checkOutput("busy_ready", 32'(req_ready), 32'h0);
            checkOutput("busy_resp_valid", 32'(resp_valid), 32'h0);
            checkOutput("busy_address", mem_address, addr & ~32'h3);
            checkOutput("busy_byte_enable", 32'(mem_byte_enable), 32'(mask));
            if (is_st && mask != 4'b0000) checkOutput("busy_wdata", mem_wdata, modelStore(wd, mask));
            if (mem_read || mem_write) cap_strobes++;
            cap_addr = mem_address;
            cap_be   = mem_byte_enable;
            cap_wdata = mem_wdata;
            if (k == lat) begin
               mem_resp  = 1'b1;
               mem_rdata = rd;
            end else begin
               mem_rdata = $urandom;
               if (hold) begin
                  req_valid  = 1'b1;
                  req_opcode = 7'($urandom);
                  req_funct3 = 3'($urandom);
                  req_addr   = $urandom;
                  req_wdata  = $urandom;
               end
            end
            @(negedge clk);
         end
         req_valid = 1'b0;
      end

      mem_resp  = 1'($urandom);
      mem_rdata = $urandom;
      checkOutput("resp_valid", 32'(resp_valid), 32'h1);
      checkOutput("resp_ready", 32'(req_ready), 32'h0);
      checkOutput("resp_strobe", 32'({mem_read, mem_write}), 32'h0);
      checkOutput("resp_rdata", resp_rdata, trap ? 32'h0 : exp_rdata);
      checkOutput("resp_trap", 32'(resp_trap), 32'(trap));
      cap_rdata = resp_rdata;
      cap_trap  = resp_trap;
      @(negedge clk);
      mem_resp = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_opcode = 7'h0;
      req_funct3 = 3'h0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      mem_resp   = 1'b0;
      mem_rdata  = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      checkOutput("rst_ready", 32'(req_ready), 32'h1);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
      checkOutput("rst_resp_trap", 32'(resp_trap), 32'h0);
      checkOutput("rst_strobes", 32'({mem_read, mem_write}), 32'h0);
      checkOutput("rst_byte_enable", 32'(mem_byte_enable), 32'h0);
      checkOutput("rst_address", mem_address, 32'h0);
      checkOutput("rst_wdata", mem_wdata, 32'h0);
      rst = 1'b0;

      applyStimulus(7'b0100011, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 2, 1'b0);
      checkOutput("lit_sb_address", cap_addr, 32'h0000_1000);
      checkOutput("lit_sb_be", 32'(cap_be), 32'h8);
      checkOutput("lit_sb_wdata", cap_wdata, 32'hA500_0000);
      checkOutput("lit_sb_strobe_cycles", 32'(cap_strobes), 32'd3);
      checkOutput("lit_sb_rdata", cap_rdata, 32'h0);

      applyStimulus(7'b0000011, 3'd0, 32'h0000_2002, 32'h0, 32'h12F0_3456, 1, 1'b0);
      checkOutput("lit_lb_be", 32'(cap_be), 32'h4);
      checkOutput("lit_lb_rdata", cap_rdata, 32'hFFFF_FFF0);
      applyStimulus(7'b0000011, 3'd4, 32'h0000_2002, 32'h0, 32'h12F0_3456, 0, 1'b0);
      checkOutput("lit_lbu_rdata", cap_rdata, 32'h0000_00F0);
      applyStimulus(7'b0000011, 3'd1, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0, 1'b0);
      checkOutput("lit_lh_be", 32'(cap_be), 32'hC);
      checkOutput("lit_lh_rdata", cap_rdata, 32'hFFFF_8001);
      applyStimulus(7'b0000011, 3'd2, 32'h0000_2000, 32'h0, 32'h8001_7FFF, 0, 1'b0);
      checkOutput("lit_lw_rdata", cap_rdata, 32'h8001_7FFF);

      applyStimulus(7'b0100011, 3'd2, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
      checkOutput("lit_sw_wdata", cap_wdata, 32'hDEAD_BEEF);
      applyStimulus(7'b0000011, 3'd2, 32'h0000_2004, 32'h0, 32'h1357_9BDF, 0, 1'b0);
      checkOutput("lit_b2b_lw_rdata", cap_rdata, 32'h1357_9BDF);

      applyStimulus(7'b0010011, 3'd0, 32'h0000_5000, 32'h1234_5678, 32'h0, 0, 1'b0);
      checkOutput("lit_nop_strobes", 32'(cap_strobes), 32'd0);

      applyStimulus(7'b0000011, 3'd2, 32'h0000_3001, 32'h0, 32'h55AA_1234, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      checkOutput("lit_mis_trap", 32'(cap_trap), 32'h1);
      checkOutput("lit_mis_strobes", 32'(cap_strobes), 32'd0);
      checkOutput("lit_mis_rdata", cap_rdata, 32'h0);
`else
      checkOutput("lit_mis_be", 32'(cap_be), 32'hF);
      checkOutput("lit_mis_trap", 32'(cap_trap), 32'h0);
      checkOutput("lit_mis_rdata", cap_rdata, 32'h55AA_1234);
`endif

      req_valid  = 1'b1;
      req_opcode = 7'b0000011;
      req_funct3 = 3'd2;
      req_addr   = 32'h0000_4000;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("rstbusy_read_before", 32'(mem_read), 32'h1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstbusy_read_after", 32'(mem_read), 32'h0);
      checkOutput("rstbusy_ready", 32'(req_ready), 32'h1);
      checkOutput("rstbusy_resp_valid", 32'(resp_valid), 32'h0);
      rst = 1'b0;
      mem_resp = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_resp = 1'b0;
      checkOutput("late_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("late_mem_read", 32'(mem_read), 32'h0);
      checkOutput("late_ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("late_resp_valid2", 32'(resp_valid), 32'h0);

      for (int t = 0; t < 300; t++) begin
         logic [6:0] op;
         int sel;
         sel = $urandom_range(0, 9);
         op = (sel < 4) ? 7'b0000011 : (sel < 8) ? 7'b0100011 : 7'($urandom);
         applyStimulus(op, 3'($urandom), $urandom, $urandom, $urandom,
                       $urandom_range(0, 3), 1'($urandom));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
